mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-requester (fetch / load-store) arbiter for a single
//                variable-latency memory port, one outstanding transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int LS_STREAK_MAX = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_done,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_gnt,
    output logic                  ls_done,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [1:0] c_streak_max = 2'(LS_STREAK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_LS_BUSY = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_ls_streak;
    logic                  w_if_gnt;
    logic                  w_ls_gnt;
    logic                  r_if_done;
    logic                  r_ls_done;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_ls_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W/8-1:0]   r_mem_wmask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load/store normally wins; fetch is forced through once the streak saturates.
    always_comb begin
        w_if_gnt    = 1'b0;
        w_ls_gnt    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (if_req && (!ls_req || (r_ls_streak == c_streak_max))) begin
                    w_if_gnt    = 1'b1;
                    w_state_nxt = ST_IF_BUSY;
                end else if (ls_req) begin
                    w_ls_gnt    = 1'b1;
                    w_state_nxt = ST_LS_BUSY;
                end
            end
            ST_IF_BUSY, ST_LS_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ls_streak <= 2'd0;
        end else if (w_if_gnt) begin
            r_ls_streak <= 2'd0;
        end else if (w_ls_gnt) begin
            if (!if_req) begin
                r_ls_streak <= 2'd0;
            end else if (r_ls_streak != c_streak_max) begin
                r_ls_streak <= r_ls_streak + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_if_done   <= 1'b0;
            r_ls_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            if (w_if_gnt) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_mem_wmask <= '0;
            end else if (w_ls_gnt) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= ls_we;
                r_mem_addr  <= ls_addr;
                r_mem_wdata <= ls_wdata;
                r_mem_wmask <= ls_wmask;
            end else if ((r_state != ST_IDLE) && mem_ready) begin
                r_mem_req <= 1'b0;
                if (r_state == ST_IF_BUSY) begin
                    r_if_rdata <= mem_rdata;
                    r_if_done  <= 1'b1;
                end else begin
                    // Stores complete without disturbing the last load result.
                    if (!r_mem_we) begin
                        r_ls_rdata <= mem_rdata;
                    end
                    r_ls_done <= 1'b1;
                end
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;
    assign if_done   = r_if_done;
    assign ls_done   = r_ls_done;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_done;
    logic [DATA_W-1:0]   if_rdata;
    logic                ls_req;
    logic                ls_we;
    logic [ADDR_W-1:0]   ls_addr;
    logic [DATA_W-1:0]   ls_wdata;
    logic [DATA_W/8-1:0] ls_wmask;
    logic                ls_gnt;
    logic                ls_done;
    logic [DATA_W-1:0]   ls_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .LS_STREAK_MAX (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wmask  (ls_wmask),
        .ls_gnt    (ls_gnt),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One char per cycle: L = ls grant, I = if grant, - = no grant.
    task automatic run_pattern(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            #1;
            chk($sformatf("%s_ls%0d", tag, i), 32'(ls_gnt), 32'(pat.getc(i) == "L"));
            chk($sformatf("%s_if%0d", tag, i), 32'(if_gnt), 32'(pat.getc(i) == "I"));
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        ls_wmask  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req",  32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_done",  32'(if_done), 32'd0);
        chk("rst_ls_done",  32'(ls_done), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single fetch, zero wait
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        chk("f_if_gnt",  32'(if_gnt), 32'd1);
        chk("f_ls_gnt",  32'(ls_gnt), 32'd0);
        chk("f_req_T",   32'(mem_req), 32'd0);
        @(negedge clk);
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        #1;
        chk("f_req_T1",  32'(mem_req), 32'd1);
        chk("f_addr",    mem_addr, 32'h0000_0010);
        chk("f_we",      32'(mem_we), 32'd0);
        chk("f_wmask",   32'(mem_wmask), 32'd0);
        chk("f_busygnt", 32'(if_gnt), 32'd0);
        chk("f_done_T1", 32'(if_done), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("f_done_T2", 32'(if_done), 32'd1);
        chk("f_rdata",   if_rdata, 32'h0050_0093);
        chk("f_req_T2",  32'(mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("f_done_T3", 32'(if_done), 32'd0);
        chk("f_rdata_h", if_rdata, 32'h0050_0093);

        // Load completes while fetch waits: ls_done and if_gnt together
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200;
        #1;
        chk("b_ls_gnt", 32'(ls_gnt), 32'd1);
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0020;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("b_if_wait", 32'(if_gnt), 32'd0);
        chk("b_addr",    mem_addr, 32'h0000_0200);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("b_ls_done",  32'(ls_done), 32'd1);
        chk("b_ls_rdata", ls_rdata, 32'h1234_5678);
        chk("b_if_gnt",   32'(if_gnt), 32'd1);
        @(negedge clk);
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_AAAA;
        #1;
        chk("b_if_addr", mem_addr, 32'h0000_0020);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("b_if_done",  32'(if_done), 32'd1);
        chk("b_if_rdata", if_rdata, 32'h0000_AAAA);

        // Store with three wait cycles; fields must stay latched
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0100;
        ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'b1111;
        #1;
        chk("s_gnt", 32'(ls_gnt), 32'd1);
        @(negedge clk);
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk($sformatf("s_req%0d", i),   32'(mem_req), 32'd1);
            chk($sformatf("s_we%0d", i),    32'(mem_we), 32'd1);
            chk($sformatf("s_addr%0d", i),  mem_addr, 32'h0000_0100);
            chk($sformatf("s_wdata%0d", i), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("s_wmask%0d", i), 32'(mem_wmask), 32'hF);
            chk($sformatf("s_done%0d", i),  32'(ls_done), 32'd0);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        chk("s_done",   32'(ls_done), 32'd1);
        chk("s_rdata",  ls_rdata, 32'h1234_5678);
        chk("s_req_lo", 32'(mem_req), 32'd0);

        // Contention with zero-wait memory
        @(negedge clk);
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; mem_ready = 1'b1;
        mem_rdata = 32'h0000_0055;
        run_pattern("cont", "L-L-I-L-L-I-");
        if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("c_if_done", 32'(if_done), 32'd1);
        chk("c_ls_rd",   ls_rdata, 32'h0000_0055);
        chk("c_if_rd",   if_rdata, 32'h0000_0055);

        // Spurious mem_ready while idle
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("sp_ifd%0d", i), 32'(if_done), 32'd0);
            chk($sformatf("sp_lsd%0d", i), 32'(ls_done), 32'd0);
            chk($sformatf("sp_req%0d", i), 32'(mem_req), 32'd0);
        end
        chk("sp_if_rd", if_rdata, 32'h0000_0055);
        chk("sp_ls_rd", ls_rdata, 32'h0000_0055);

        // Reset mid-transaction (streak is 1 just before reset)
        @(negedge clk);
        mem_ready = 1'b0;
        ls_req = 1'b1; if_req = 1'b1; ls_addr = 32'h0000_0300;
        #1;
        chk("r_ls_gnt", 32'(ls_gnt), 32'd1);
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b0;
        #1;
        chk("r_busy", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_req_drop", 32'(mem_req), 32'd0);
        chk("r_addr_clr", mem_addr, 32'd0);
        chk("r_ls_rd",    ls_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("r_nodone0", 32'(ls_done), 32'd0);
        @(negedge clk);
        #1;
        chk("r_nodone1", 32'(ls_done), 32'd0);
        chk("r_req_lo",  32'(mem_req), 32'd0);
        if_req = 1'b1; ls_req = 1'b1; mem_ready = 1'b1;
        run_pattern("post", "L-L-I-");
        if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
